// File: rtl/enemy_anim_ctrl.sv
// enemy_anim_ctrl: sprite addressing, walk-cycle animation and hit/hurt/dead
// state for one enemy sprite. All state lives on Clk; frame_clk and hit are
// asynchronous to it and are brought in through synchronisers.
// Sprite area (SPR_W*SPR_H) is expected to stay at or below 6001 so that every
// address fits the sprite ROM.
module enemy_anim_ctrl #(
  parameter int SPR_W           = 60,
  parameter int SPR_H           = 100,
  parameter int FRAMES_PER_STEP = 8,
  parameter int HURT_FRAMES     = 16,
  parameter int MAX_HITS        = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  EnemyX,
  input  logic [9:0]  EnemyY,
  input  logic        enemy_left,
  input  logic        moving,
  input  logic        hit,
  output logic [15:0] read_address,
  output logic [1:0]  en_move,
  output logic        beida,
  output logic        is_enemy,
  output logic        alive
);

  localparam int WC_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int HC_W  = (HURT_FRAMES > 1) ? $clog2(HURT_FRAMES) : 1;
  localparam int HIT_W = $clog2(MAX_HITS + 1);

  localparam logic [WC_W-1:0]   WC_LAST  = WC_W'(FRAMES_PER_STEP - 1);
  localparam logic [HC_W-1:0]   HC_LAST  = HC_W'(HURT_FRAMES - 1);
  localparam logic [HIT_W-1:0]  HITS_MAX = HIT_W'(MAX_HITS);
  localparam logic signed [10:0] SPR_W11 = 11'(SPR_W);
  localparam logic signed [10:0] SPR_H11 = 11'(SPR_H);
  localparam logic [15:0]        SPR_W16 = 16'(SPR_W);

  typedef enum logic [1:0] {
    ST_ALIVE = 2'd0,
    ST_HURT  = 2'd1,
    ST_DEAD  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronisers and rising-edge detectors
  // ---------------------------------------------------------------------------
  logic fc_s1_q, fc_s1_d, fc_s2_q, fc_s2_d, fc_prev_q, fc_prev_d;
  logic ht_s1_q, ht_s1_d, ht_s2_q, ht_s2_d, ht_prev_q, ht_prev_d;
  logic tick, hit_p;

  // Next values of the two-flop synchronisers plus the edge-history flop.
  always_comb begin
    fc_s1_d   = frame_clk;
    fc_s2_d   = fc_s1_q;
    fc_prev_d = fc_s2_q;
    ht_s1_d   = hit;
    ht_s2_d   = ht_s1_q;
    ht_prev_d = ht_s2_q;
  end

  // Synchroniser registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fc_s1_q   <= 1'b0;
      fc_s2_q   <= 1'b0;
      fc_prev_q <= 1'b0;
      ht_s1_q   <= 1'b0;
      ht_s2_q   <= 1'b0;
      ht_prev_q <= 1'b0;
    end else begin
      fc_s1_q   <= fc_s1_d;
      fc_s2_q   <= fc_s2_d;
      fc_prev_q <= fc_prev_d;
      ht_s1_q   <= ht_s1_d;
      ht_s2_q   <= ht_s2_d;
      ht_prev_q <= ht_prev_d;
    end
  end

  assign tick  = fc_s2_q & ~fc_prev_q;
  assign hit_p = ht_s2_q & ~ht_prev_q;

  // ---------------------------------------------------------------------------
  // Hit FSM
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [HIT_W-1:0] hits_q, hits_d;
  logic [HC_W-1:0]  hurt_cnt_q, hurt_cnt_d;

  // Next state: hits only count while ALIVE; HURT lasts HURT_FRAMES ticks;
  // DEAD is sticky until Reset.
  always_comb begin
    state_d    = state_q;
    hits_d     = hits_q;
    hurt_cnt_d = hurt_cnt_q;
    case (state_q)
      ST_ALIVE: begin
        if (hit_p) begin
          hits_d = hits_q + HIT_W'(1);
          if (hits_d == HITS_MAX) begin
            state_d = ST_DEAD;
          end else begin
            state_d    = ST_HURT;
            hurt_cnt_d = '0;
          end
        end
      end
      ST_HURT: begin
        if (tick) begin
          if (hurt_cnt_q == HC_LAST) begin
            state_d    = ST_ALIVE;
            hurt_cnt_d = '0;
          end else begin
            hurt_cnt_d = hurt_cnt_q + HC_W'(1);
          end
        end
      end
      ST_DEAD: begin
        state_d = ST_DEAD;
      end
      default: begin
        state_d    = ST_ALIVE;
        hits_d     = '0;
        hurt_cnt_d = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_ALIVE;
      hits_q     <= '0;
      hurt_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hits_q     <= hits_d;
      hurt_cnt_q <= hurt_cnt_d;
    end
  end

  assign beida = (state_q != ST_ALIVE);
  assign alive = (state_q != ST_DEAD);

  // ---------------------------------------------------------------------------
  // Walk animation
  // ---------------------------------------------------------------------------
  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic [1:0]      phase_q, phase_d;

  // Walk counter: cleared when standing, frozen while hurt or dead. A tick in
  // the same cycle as a hit still counts, since the state is ALIVE then.
  always_comb begin
    wcnt_d  = wcnt_q;
    phase_d = phase_q;
    if (!moving) begin
      wcnt_d  = '0;
      phase_d = 2'd0;
    end else if (tick && (state_q == ST_ALIVE)) begin
      if (wcnt_q == WC_LAST) begin
        wcnt_d  = '0;
        phase_d = phase_q + 2'd1;
      end else begin
        wcnt_d = wcnt_q + WC_W'(1);
      end
    end
  end

  // Walk counter registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wcnt_q  <= '0;
      phase_q <= 2'd0;
    end else begin
      wcnt_q  <= wcnt_d;
      phase_q <= phase_d;
    end
  end

  // Phase to frame select: stand, step A, stand, step B.
  always_comb begin
    en_move = 2'b00;
    case (phase_q)
      2'd1:    en_move = 2'b01;
      2'd3:    en_move = 2'b10;
      default: en_move = 2'b00;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pixel addressing
  // ---------------------------------------------------------------------------
  logic signed [10:0] dx, dy, col;
  logic               in_box;
  logic [15:0]        addr;
  logic [15:0]        read_address_q, read_address_d;
  logic               inbox_d1_q, inbox_d1_d;
  logic               is_enemy_q, is_enemy_d;

  // Sprite-relative coordinate, mirrored column and ROM address.
  always_comb begin
    dx     = $signed({1'b0, DrawX}) - $signed({1'b0, EnemyX});
    dy     = $signed({1'b0, DrawY}) - $signed({1'b0, EnemyY});
    col    = enemy_left ? (SPR_W11 - 11'sd1 - dx) : dx;
    in_box = (dx >= 11'sd0) && (dx < SPR_W11) &&
             (dy >= 11'sd0) && (dy < SPR_H11) && alive;
    addr   = ({5'b0, dy} * SPR_W16) + {5'b0, col};
    read_address_d = in_box ? addr : 16'd0;
    inbox_d1_d     = in_box;
    is_enemy_d     = inbox_d1_q;
  end

  // Address register and the two-stage in-box delay that lines is_enemy up
  // with the ROM's registered colour output.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      read_address_q <= 16'd0;
      inbox_d1_q     <= 1'b0;
      is_enemy_q     <= 1'b0;
    end else begin
      read_address_q <= read_address_d;
      inbox_d1_q     <= inbox_d1_d;
      is_enemy_q     <= is_enemy_d;
    end
  end

  assign read_address = read_address_q;
  assign is_enemy     = is_enemy_q;

endmodule

// File: tb/tb_enemy_anim_ctrl.sv
// Bench for enemy_anim_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural model.
module tb_enemy_anim_ctrl;

  localparam int SPR_W = 60;
  localparam int SPR_H = 100;
  localparam int FPS   = 8;
  localparam int HURTF = 16;
  localparam int MAXH  = 3;

  logic        Clk, Reset, frame_clk, enemy_left, moving, hit;
  logic [9:0]  DrawX, DrawY, EnemyX, EnemyY;
  logic [15:0] read_address;
  logic [1:0]  en_move;
  logic        beida, is_enemy, alive;

  enemy_anim_ctrl #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES_PER_STEP(FPS),
    .HURT_FRAMES(HURTF), .MAX_HITS(MAXH)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .DrawX(DrawX), .DrawY(DrawY), .EnemyX(EnemyX), .EnemyY(EnemyY),
    .enemy_left(enemy_left), .moving(moving), .hit(hit),
    .read_address(read_address), .en_move(en_move), .beida(beida),
    .is_enemy(is_enemy), .alive(alive)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int vectors = 0;
  int errors  = 0;

  // Behavioural model: life status, hit count, ticks spent hurt, ticks walked
  // since the enemy started moving, and sample histories of the async inputs.
  localparam int M_ALIVE = 0, M_HURT = 1, M_DEAD = 2;
  int m_st, m_hits, m_hurt_ticks, m_walk_ticks;
  int m_ra, m_ie, m_inbox_prev;
  bit fc_hist[3];
  bit ht_hist[3];

  task automatic model_reset();
    m_st = M_ALIVE; m_hits = 0; m_hurt_ticks = 0; m_walk_ticks = 0;
    m_ra = 0; m_ie = 0; m_inbox_prev = 0;
    for (int i = 0; i < 3; i++) begin fc_hist[i] = 0; ht_hist[i] = 0; end
  endtask

  // One clock edge worth of behaviour, using the inputs present at the edge.
  task automatic model_step();
    bit t, hp;
    int dx, dy, col, inb;
    if (Reset) begin model_reset(); return; end
    // Edges are seen two samples late (synchroniser depth).
    t  = fc_hist[1] && !fc_hist[2];
    hp = ht_hist[1] && !ht_hist[2];
    dx  = int'(DrawX) - int'(EnemyX);
    dy  = int'(DrawY) - int'(EnemyY);
    inb = (dx >= 0 && dx < SPR_W && dy >= 0 && dy < SPR_H && m_st != M_DEAD) ? 1 : 0;
    col = enemy_left ? (SPR_W - 1 - dx) : dx;
    m_ie = m_inbox_prev;
    m_inbox_prev = inb;
    m_ra = inb ? (dy * SPR_W + col) : 0;
    if (!moving) m_walk_ticks = 0;
    else if (t && m_st == M_ALIVE) m_walk_ticks++;
    case (m_st)
      M_ALIVE: if (hp) begin
        m_hits++;
        if (m_hits == MAXH) m_st = M_DEAD;
        else begin m_st = M_HURT; m_hurt_ticks = 0; end
      end
      M_HURT: if (t) begin
        m_hurt_ticks++;
        if (m_hurt_ticks == HURTF) m_st = M_ALIVE;
      end
      default: ;
    endcase
    fc_hist[2] = fc_hist[1]; fc_hist[1] = fc_hist[0]; fc_hist[0] = frame_clk;
    ht_hist[2] = ht_hist[1]; ht_hist[1] = ht_hist[0]; ht_hist[0] = hit;
  endtask

  function automatic int exp_en_move();
    int step;
    step = (m_walk_ticks / FPS) % 4;
    return (step == 1) ? 1 : (step == 3) ? 2 : 0;
  endfunction

  // Compare all outputs against the model.
  task automatic check_all();
    vectors++;
    if (read_address !== 16'(m_ra)) begin errors++;
      $display("FAIL read_address t=%0t got %0d want %0d", $time, read_address, m_ra); end
    if (is_enemy !== 1'(m_ie)) begin errors++;
      $display("FAIL is_enemy t=%0t got %0b want %0d", $time, is_enemy, m_ie); end
    if (en_move !== 2'(exp_en_move())) begin errors++;
      $display("FAIL en_move t=%0t got %0d want %0d", $time, en_move, exp_en_move()); end
    if (beida !== (m_st != M_ALIVE)) begin errors++;
      $display("FAIL beida t=%0t got %0b want %0b", $time, beida, m_st != M_ALIVE); end
    if (alive !== (m_st != M_DEAD)) begin errors++;
      $display("FAIL alive t=%0t got %0b want %0b", $time, alive, m_st != M_DEAD); end
  endtask

  // Literal expectation pinning the model and the DUT together.
  task automatic pin(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp); end
  endtask

  task automatic cyc();
    @(posedge Clk);
    model_step();
    @(negedge Clk);
    check_all();
  endtask

  task automatic frame_tick();
    frame_clk = 1'b1; cyc(); cyc();
    frame_clk = 1'b0; cyc(); cyc();
  endtask

  task automatic hit_pulse();
    hit = 1'b1; cyc(); cyc(); cyc();
    hit = 1'b0; cyc();
  endtask

  task automatic async_reset();
    Reset = 1'b1;
    #1;
    model_reset();
    check_all();
    pin("rst_alive", alive, 1);
    pin("rst_beida", beida, 0);
    pin("rst_is_enemy", is_enemy, 0);
    pin("rst_en_move", en_move, 0);
    pin("rst_read_address", read_address, 0);
    cyc();
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; frame_clk = 0; hit = 0; moving = 0; enemy_left = 0;
    DrawX = 0; DrawY = 0; EnemyX = 100; EnemyY = 50;
    model_reset();
    #2;
    check_all();
    pin("init_alive", alive, 1);
    pin("init_read_address", read_address, 0);
    @(negedge Clk);
    Reset = 1'b0;
    cyc();

    // Pixel addressing.
    DrawX = 105; DrawY = 52; enemy_left = 0;
    cyc(); pin("addr_right", read_address, 125);
    cyc(); pin("is_enemy_2cyc", is_enemy, 1);
    enemy_left = 1;
    cyc(); pin("addr_left", read_address, 174);
    DrawX = 99;
    cyc(); pin("addr_outside", read_address, 0);
    cyc(); pin("is_enemy_outside", is_enemy, 0);
    DrawX = 105;

    // Walk cycle.
    moving = 1;
    for (int i = 0; i < 7; i++) frame_tick();
    pin("walk_7", en_move, 0);
    frame_tick(); pin("walk_8", en_move, 1);
    for (int i = 0; i < 8; i++) frame_tick();
    pin("walk_16", en_move, 0);
    for (int i = 0; i < 8; i++) frame_tick();
    pin("walk_24", en_move, 2);
    moving = 0;
    cyc(); pin("walk_stop", en_move, 0);
    moving = 1;

    // Hurt period with an ignored second hit.
    hit_pulse(); pin("hurt_on", beida, 1);
    for (int i = 0; i < 5; i++) frame_tick();
    hit_pulse();
    for (int i = 0; i < 10; i++) frame_tick();
    pin("hurt_15", beida, 1);
    frame_tick(); pin("hurt_16", beida, 0);
    hit_pulse();
    for (int i = 0; i < 16; i++) frame_tick();
    pin("alive_after_2", alive, 1);
    pin("beida_after_2", beida, 0);
    hit_pulse();
    pin("dead_alive", alive, 0);
    pin("dead_beida", beida, 1);
    enemy_left = 0;
    cyc(); cyc(); pin("dead_is_enemy", is_enemy, 0);
    async_reset();

    // Tick and hit in the same cycle, then reset mid-hurt.
    moving = 1;
    for (int i = 0; i < 7; i++) frame_tick();
    frame_clk = 1; hit = 1; cyc(); cyc();
    frame_clk = 0; cyc(); cyc();
    hit = 0; cyc();
    pin("same_beida", beida, 1);
    pin("same_walk", en_move, 1);
    frame_tick(); frame_tick();
    #2;
    async_reset();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      int off;
      if ($urandom_range(0, 3) == 0) frame_clk = ~frame_clk;
      if ($urandom_range(0, 99) < 3) hit = ~hit;
      if ($urandom_range(0, 99) < 2) moving = ~moving;
      if ($urandom_range(0, 31) == 0) begin
        EnemyX = 10'($urandom_range(0, 1023));
        EnemyY = 10'($urandom_range(0, 1023));
        enemy_left = 1'($urandom_range(0, 1));
      end
      off   = int'($urandom_range(0, SPR_W + 10)) - 5;
      DrawX = 10'(int'(EnemyX) + off);
      off   = int'($urandom_range(0, SPR_H + 10)) - 5;
      DrawY = 10'(int'(EnemyY) + off);
      Reset = ($urandom_range(0, 499) == 0);
      if (Reset) model_reset();
      cyc();
    end
    Reset = 0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/enemy_anim_ctrl.md
ENEMY_ANIM_CTRL -- requirements
Module: enemy_anim_ctrl

Interface
REQ-001 Parameter SPR_W, default 60, sprite width in pixels.
REQ-002 Parameter SPR_H, default 100, sprite height in pixels; SPR_W*SPR_H SHALL NOT exceed 6001.
REQ-003 Parameter FRAMES_PER_STEP, default 8, frame ticks per walk-animation step.
REQ-004 Parameter HURT_FRAMES, default 16, frame ticks the hurt pose is held.
REQ-005 Parameter MAX_HITS, default 3, hits that kill the enemy.
REQ-006 Clk  in  1  single system clock; all state SHALL be on its rising edge.
REQ-007 Reset  in  1  asynchronous, active-high reset.
REQ-008 frame_clk  in  1  per-frame signal; each rising edge is one frame tick.
REQ-009 DrawX, DrawY  in  10 each  current pixel coordinate.
REQ-010 EnemyX, EnemyY  in  10 each  sprite top-left position.
REQ-011 enemy_left  in  1  1 = facing left, so the sprite is mirrored horizontally.
REQ-012 moving  in  1  1 = enemy walking.
REQ-013 hit  in  1  level signal; its rising edge is one hit request.
REQ-014 read_address  out  16  sprite ROM address.
REQ-015 en_move  out  2  walk frame select (00 stand, 01 step A, 10 step B).
REQ-016 beida  out  1  1 = hurt pose selected.
REQ-017 is_enemy  out  1  pixel lies inside the sprite, aligned with ROM colour output.
REQ-018 alive  out  1  1 = enemy not dead.

Function
REQ-019 frame_clk SHALL pass through a 2-flop synchroniser, then a rising-edge detector producing the one-cycle pulse tick; hit SHALL use an identical structure producing hit_p.
REQ-020 dx = DrawX-EnemyX and dy = DrawY-EnemyY SHALL be computed as 11-bit signed values; in_box = (0<=dx<SPR_W)&&(0<=dy<SPR_H)&&alive.
REQ-021 col = enemy_left ? SPR_W-1-dx : dx; read_address SHALL be registered as dy*SPR_W+col when in_box, else 0 (1-cycle latency).
REQ-022 is_enemy SHALL be in_box delayed 2 cycles, to match the registered read_address plus the ROM's one-cycle registered colour stage.
REQ-023 Walk counter wcnt (0..FRAMES_PER_STEP-1) SHALL advance on tick while moving; on wrap, phase (2-bit) SHALL increment modulo 4.
REQ-024 en_move SHALL map phase 0->00, 1->01, 2->00, 3->10; when moving=0, wcnt, phase and en_move SHALL clear to 0 on the next cycle.
REQ-025 Hit FSM states: ALIVE, HURT, DEAD.
REQ-026 ALIVE + hit_p: hits increments; if the new count equals MAX_HITS go DEAD, else go HURT with hurt_cnt=0.
REQ-027 HURT: beida=1; hurt_cnt SHALL increment on tick; on the tick at which hurt_cnt==HURT_FRAMES-1 return to ALIVE.
REQ-028 hit_p in HURT or DEAD SHALL be ignored, with hits unchanged.
REQ-029 DEAD: alive=0, beida=1, is_enemy=0 within 2 cycles; DEAD is exited only by Reset.
REQ-030 beida=1 SHALL override walk animation; wcnt and phase SHALL hold during HURT.
REQ-031 When tick and hit_p occur in the same cycle in ALIVE, the hit SHALL take priority; the tick SHALL still advance the walk counter.

Reset
REQ-032 Reset SHALL immediately and asynchronously force: state=ALIVE, hits=0, hurt_cnt=0, wcnt=0, phase=0, synchronisers=0, read_address=0, en_move=00, beida=0, is_enemy=0, alive=1.
REQ-033 Reset asserted mid-HURT or in DEAD SHALL return to ALIVE with no residual hit count.

Verification
REQ-034 EnemyX=100, EnemyY=50, DrawX=105, DrawY=52, enemy_left=0 -> read_address=125 one cycle later; is_enemy=1 two cycles later.
REQ-035 Same pixel with enemy_left=1 -> read_address=174; DrawX=99 -> read_address=0 and is_enemy=0.
REQ-036 moving=1, 32 frame ticks -> en_move sequence 00,01,00,10, changing every 8 ticks; drop moving -> 00 next cycle.
REQ-037 One hit pulse -> beida=1 for exactly 16 ticks, then 0; a second hit during HURT -> no extension and hits unchanged.
REQ-038 Three hits, each separated by a full HURT period -> alive=0, is_enemy stays 0 everywhere; Reset -> alive=1, beida=0.
REQ-039 tick and hit edge in the same cycle -> HURT entered and wcnt advanced; Reset pulsed mid-HURT -> all outputs at reset values without waiting for a Clk edge.
